// File: rtl/nios_ii_system_pio_in_irq.sv
// -----------------------------------------------------------------------------
// nios_ii_system_pio_in_irq
//
// Avalon-MM slave input port for board-level inputs (switches, keys,
// card-detect) feeding the Nios II data master. Each input bit passes through a
// synchroniser, an optional per-bit debounce filter and an edge detector. Edges
// are latched in a write-1-to-clear capture register. A maskable interrupt is
// driven from either the captured edges or the filtered input level.
//
// Register map (word address, bits above WIDTH-1 read as 0):
//   0 data           RO     filtered input value
//   1 reserved       RO     reads 0
//   2 interruptmask  RW     bit n enables bit n into irq
//   3 edgecapture    R/W1C  writing 1 to bit n clears it
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    registered read data
//   irq         interrupt request, active-high
//
// Bus handshake: the slave never stalls. A write is accepted on the clk edge
// where chipselect=1 and write_n=0. readdata is refreshed from address on
// every clk edge (no chipselect gating), so read data is valid one clock after
// the address is presented.
// -----------------------------------------------------------------------------
module nios_ii_system_pio_in_irq #(
   parameter int              WIDTH           = 12,
   parameter int              SYNC_STAGES     = 2,
   parameter int              DEBOUNCE_CYCLES = 0,
   parameter int              EDGE_TYPE       = 0,
   parameter int              IRQ_MODE        = 1,
   parameter logic [WIDTH-1:0] RESET_MASK     = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // Edge detection stays disabled until the synchroniser and the filter have
   // had time to absorb whatever level the inputs held at reset release.
   localparam int GUARD = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
   localparam int GW    = $clog2(GUARD + 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] filtered;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_raw;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] int_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [GW-1:0]    guard_cnt;
   logic             guard_done;
   logic             wr_en;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   // Upper writedata bits are only meaningful when WIDTH is 32.
   assign unused_wdata = ^writedata;

   assign wr_en = chipselect & ~write_n;

   // ---------------------------------------------------------------- sync
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------ debounce
   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign filtered = sync_out;
      end else begin : g_debounce
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         // The cycle in which sync_out changes clears the counter, so the
         // counter only has to cover the remaining DEBOUNCE_CYCLES-1 stable
         // cycles: a level must be held DEBOUNCE_CYCLES cycles to pass.
         localparam logic [CW-1:0] THR =
            CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);

         logic [WIDTH-1:0] sync_last;
         logic [WIDTH-1:0] filt_r;
         logic [CW-1:0]    cnt [WIDTH];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync_last <= '0;
               filt_r    <= '0;
               for (int b = 0; b < WIDTH; b++) begin
                  cnt[b] <= '0;
               end
            end else begin
               sync_last <= sync_out;
               for (int b = 0; b < WIDTH; b++) begin
                  if ((sync_out[b] == filt_r[b]) || (sync_out[b] != sync_last[b])) begin
                     cnt[b] <= '0;
                  end else if (cnt[b] == THR) begin
                     filt_r[b] <= sync_out[b];
                     cnt[b]    <= '0;
                  end else begin
                     cnt[b] <= cnt[b] + CW'(1);
                  end
               end
            end
         end

         assign filtered = filt_r;
      end
   endgenerate

   // ------------------------------------------------------- startup guard
   assign guard_done = (guard_cnt == GW'(GUARD));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         guard_cnt <= '0;
      end else if (!guard_done) begin
         guard_cnt <= guard_cnt + GW'(1);
      end
   end

   // --------------------------------------------------------- edge detect
   // prev follows filtered during the guard too, so a level already present
   // at reset release is never seen as an edge once the guard lifts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev <= '0;
      end else begin
         prev <= filtered;
      end
   end

   assign rise = filtered & ~prev;
   assign fall = ~filtered & prev;

   always_comb begin
      edge_raw = '0;
      case (EDGE_TYPE)
         0:       edge_raw = rise;
         1:       edge_raw = fall;
         default: edge_raw = rise | fall;
      endcase
   end

   assign edge_hit = guard_done ? edge_raw : '0;
   assign edge_clr = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

   // ------------------------------------------------------------ registers
   // A new edge wins over a simultaneous W1C of the same bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_cap <= '0;
         int_mask <= RESET_MASK;
      end else begin
         edge_cap <= (edge_cap & ~edge_clr) | edge_hit;
         if (wr_en && (address == ADDR_MASK)) begin
            int_mask <= writedata[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: rd_mux[WIDTH-1:0] = filtered;
         ADDR_MASK: rd_mux[WIDTH-1:0] = int_mask;
         ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

   // ------------------------------------------------------------------ irq
   generate
      if (IRQ_MODE == 1) begin : g_irq_edge
         assign irq = |(edge_cap & int_mask);
      end else begin : g_irq_level
         assign irq = |(filtered & int_mask);
      end
   endgenerate

endmodule

// File: tb/tb_nios_ii_system_pio_in_irq.sv
// -----------------------------------------------------------------------------
// tb_nios_ii_system_pio_in_irq
//
// Three instances share one stimulus stream:
//   inst 0 (a): default parameters
//   inst 1 (b): SYNC_STAGES=3, DEBOUNCE_CYCLES=4
//   inst 2 (c): EDGE_TYPE=2 (any edge), IRQ_MODE=0 (level), RESET_MASK=12'h010
// A reference model steps once per clock edge; reads push the expected data
// of all three instances into exp_q and a monitor pops and compares one clock
// later. irq is compared against the model on every falling edge.
// -----------------------------------------------------------------------------
module tb_nios_ii_system_pio_in_irq;

   // ------------------------------------------------------- clock / reset
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [11:0] in_port;
   logic [31:0] rd_a, rd_b, rd_c;
   logic        irq_a, irq_b, irq_c;

   logic        rd_chk  = 1'b0;
   logic        started = 1'b0;
   int          tests_run    = 0;
   int          tests_failed = 0;

   always #5 clk = ~clk;

   nios_ii_system_pio_in_irq dut_a (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_a), .irq(irq_a)
   );

   nios_ii_system_pio_in_irq #(
      .WIDTH(12), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0),
      .IRQ_MODE(1), .RESET_MASK(12'h000)
   ) dut_b (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_b), .irq(irq_b)
   );

   nios_ii_system_pio_in_irq #(
      .WIDTH(12), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2),
      .IRQ_MODE(0), .RESET_MASK(12'h010)
   ) dut_c (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_c), .irq(irq_c)
   );

   // ------------------------------------------------------ reference model
   function automatic int ss_of(input int i); return (i == 1) ? 3 : 2; endfunction
   function automatic int dc_of(input int i); return (i == 1) ? 4 : 0; endfunction
   function automatic int et_of(input int i); return (i == 2) ? 2 : 0; endfunction
   function automatic int im_of(input int i); return (i == 2) ? 0 : 1; endfunction
   function automatic logic [11:0] rm_of(input int i);
      return (i == 2) ? 12'h010 : 12'h000;
   endfunction

   // hist[k % 16] = in_port sampled at the k-th clock edge since reset release
   logic [11:0] hist [16];
   int          age = 0;
   logic [11:0] filt_m [3];
   logic [11:0] last_s [3];
   logic [11:0] prev_m [3];
   logic [11:0] ecap_m [3];
   logic [11:0] mask_m [3];
   int          run_m  [3][12];
   logic [95:0] exp_q [$];

   // Synchronised value seen just before edge k: the input as sampled
   // SYNC_STAGES edges earlier, or 0 if that lies before reset release.
   function automatic logic [11:0] sync_at(input int i, input int k);
      if (k - 1 >= ss_of(i)) return hist[(k - ss_of(i)) % 16];
      return 12'h000;
   endfunction

   function automatic logic [11:0] filt_now(input int i, input int k);
      if (dc_of(i) == 0) return sync_at(i, k);
      return filt_m[i];
   endfunction

   function automatic logic [31:0] rdv(input int i, input int k);
      logic [31:0] r;
      r = 32'h0;
      case (address)
         2'd0:    r[11:0] = filt_now(i, k);
         2'd2:    r[11:0] = mask_m[i];
         2'd3:    r[11:0] = ecap_m[i];
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic logic irq_m(input int i);
      logic [11:0] f;
      f = filt_now(i, age + 1);
      if (im_of(i) == 1) return |(ecap_m[i] & mask_m[i]);
      return |(f & mask_m[i]);
   endfunction

   always @(posedge clk or posedge reset) begin : model_step
      logic [11:0] f, ed, s, clr;
      int k;
      if (reset) begin
         age = 0;
         for (int i = 0; i < 3; i++) begin
            filt_m[i] = 12'h0; last_s[i] = 12'h0; prev_m[i] = 12'h0;
            ecap_m[i] = 12'h0; mask_m[i] = rm_of(i);
            for (int b = 0; b < 12; b++) run_m[i][b] = 0;
         end
         exp_q.delete();
      end else begin
         k = age + 1;
         hist[k % 16] = in_port;
         if (rd_chk) exp_q.push_back({rdv(2, k), rdv(1, k), rdv(0, k)});
         clr = (chipselect && !write_n && address == 2'd3) ? writedata[11:0] : 12'h0;
         for (int i = 0; i < 3; i++) begin
            f = filt_now(i, k);
            case (et_of(i))
               0:       ed = f & ~prev_m[i];
               1:       ed = ~f & prev_m[i];
               default: ed = f ^ prev_m[i];
            endcase
            if (k <= ss_of(i) + dc_of(i) + 1) ed = 12'h0;
            ecap_m[i] = (ecap_m[i] & ~clr) | ed;
            if (chipselect && !write_n && address == 2'd2) mask_m[i] = writedata[11:0];
            prev_m[i] = f;
            if (dc_of(i) > 0) begin
               s = sync_at(i, k);
               for (int b = 0; b < 12; b++) begin
                  run_m[i][b] = (s[b] == last_s[i][b]) ? run_m[i][b] + 1 : 1;
                  if (s[b] != filt_m[i][b] && run_m[i][b] == dc_of(i)) filt_m[i][b] = s[b];
               end
               last_s[i] = s;
            end
         end
         age = k;
      end
   end

   // ----------------------------------------------------------- scoreboard
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [95:0] e;
      if (started) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("readdata_a", rd_a, e[31:0]);
            check("readdata_b", rd_b, e[63:32]);
            check("readdata_c", rd_c, e[95:64]);
         end
         check("irq_a", {31'b0, irq_a}, {31'b0, irq_m(0)});
         check("irq_b", {31'b0, irq_b}, {31'b0, irq_m(1)});
         check("irq_c", {31'b0, irq_c}, {31'b0, irq_m(2)});
      end
   end

   // -------------------------------------------------------------- drivers
   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      cycles(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a);
      address = a; rd_chk = 1'b1;
      cycles(1);
      rd_chk = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------- stimulus
   initial begin
      reset = 1'b1; in_port = 12'h000; address = 2'd0;
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
      cycles(3);
      reset = 1'b0;
      started = 1'b1;
      check("reset_readdata", rd_a, 32'h0);
      check("reset_irq", {31'b0, irq_a}, 32'h0);
      for (int a = 0; a < 4; a++) bus_read(2'(a));
      cycles(12);

      // 1: step to A5C; data reaches readdata on the third edge
      in_port = 12'hA5C; address = 2'd0; rd_chk = 1'b1;
      cycles(2);
      check("t1_before_latency", rd_a, 32'h0);
      cycles(1);
      check("t1_data", rd_a, 32'hA5C);
      rd_chk = 1'b0;
      cycles(10);
      bus_write(2'd3, 32'hFFF);

      // 2: mask bit0, rising edge on bit0, then W1C
      bus_write(2'd2, 32'h001);
      in_port = 12'hA5D;
      cycles(5);
      check("t2_irq_set", {31'b0, irq_a}, 32'h1);
      bus_read(2'd3);
      check("t2_edgecap", rd_a, 32'h001);
      bus_write(2'd3, 32'h001);
      check("t2_irq_clr", {31'b0, irq_a}, 32'h0);

      // 3: rising edge on bit3 in the same cycle as its W1C
      in_port = 12'h000;
      cycles(10);
      bus_write(2'd3, 32'hFFF);
      in_port = 12'h008;
      cycles(2);
      bus_write(2'd3, 32'h008);
      bus_read(2'd3);
      check("t3_edge_wins", rd_a, 32'h008);

      // 4: inputs high through reset release
      in_port = 12'hFFF;
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(15);
      bus_read(2'd3);
      check("t4_no_edge", rd_a, 32'h0);
      check("t4_irq", {31'b0, irq_a}, 32'h0);

      // 5: debounce on instance b
      in_port = 12'h000;
      cycles(15);
      bus_write(2'd3, 32'hFFF);
      in_port = 12'h004;
      cycles(3);
      in_port = 12'h000;
      cycles(12);
      bus_read(2'd0);
      check("t5_short_data", rd_b, 32'h0);
      bus_read(2'd3);
      check("t5_short_edge", rd_b, 32'h0);
      in_port = 12'h004;
      cycles(6);
      in_port = 12'h000;
      cycles(3);
      bus_read(2'd0);
      check("t5_long_data", rd_b, 32'h004);
      cycles(8);
      bus_read(2'd3);
      check("t5_long_edge", rd_b, 32'h004);

      // 6: any-edge capture and level irq on instance c, reset mid-pulse
      bus_write(2'd2, 32'h0F0);
      bus_write(2'd2, 32'h010);
      bus_write(2'd3, 32'hFFF);
      in_port = 12'h010;
      cycles(4);
      check("t6_irq_high", {31'b0, irq_c}, 32'h1);
      bus_read(2'd3);
      check("t6_rise_cap", rd_c, 32'h010);
      bus_write(2'd3, 32'h010);
      in_port = 12'h000;
      cycles(4);
      check("t6_irq_low", {31'b0, irq_c}, 32'h0);
      bus_read(2'd3);
      check("t6_fall_cap", rd_c, 32'h010);
      in_port = 12'h010;
      cycles(4);
      bus_write(2'd2, 32'h0F0);
      reset = 1'b1;
      cycles(1);
      check("t6_reset_rd", rd_c, 32'h0);
      check("t6_reset_irq", {31'b0, irq_c}, 32'h0);
      reset = 1'b0;
      bus_read(2'd2);
      check("t6_reset_mask", rd_c, 32'h010);
      bus_read(2'd3);
      check("t6_reset_edge", rd_c, 32'h0);
      cycles(10);

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         if (n == 300) begin
            rd_chk = 1'b0; chipselect = 1'b0; write_n = 1'b1;
            reset = 1'b1;
            cycles(2);
            reset = 1'b0;
         end
         if ($urandom_range(0, 4) == 0) in_port = 12'($urandom);
         address    = 2'($urandom_range(0, 3));
         chipselect = 1'($urandom_range(0, 1));
         write_n    = ($urandom_range(0, 3) != 0);
         writedata  = $urandom;
         rd_chk     = 1'b1;
         cycles(1);
      end
      rd_chk = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      cycles(3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
